// File: rtl/flag_register_unit.sv
// Status-flag register {S,Z,C,V} fed from ALU results, with direct load and a
// 4-deep save/restore stack. Illegal stack requests pulse err for one cycle.
module flag_register_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_kind,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] res,
  input  logic        c_alu,
  input  logic        wr_en,
  input  logic [3:0]  wr_flag,
  input  logic        push,
  input  logic        pop,
  output logic [3:0]  FLAG,
  output logic [2:0]  depth,
  output logic        stack_full,
  output logic        stack_empty,
  output logic        err
);

  localparam int STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    KIND_ADD   = 2'b00,
    KIND_SUB   = 2'b01,
    KIND_LOGIC = 2'b10,
    KIND_SHIFT = 2'b11
  } op_kind_e;

  logic [3:0] flag_q, flag_d;
  logic [2:0] depth_q, depth_d;
  logic       err_q, err_d;

  logic [3:0] stack_mem [STACK_DEPTH];

  logic       alu_s, alu_z, alu_c, alu_v;
  logic [3:0] alu_flag;
  logic       conflict, pop_ok, push_ok;
  logic [1:0] top_idx;
  logic       unused_operand_bits;

  // Only the sign bits of the operands matter for overflow detection.
  assign unused_operand_bits = ^{a[14:0], b[14:0]};

  always_comb begin
    alu_s = res[15];
    alu_z = (res == 16'h0000);
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_kind_e'(op_kind))
      KIND_ADD: begin
        alu_c = c_alu;
        alu_v = (a[15] == b[15]) && (res[15] != a[15]);
      end
      KIND_SUB: begin
        alu_c = c_alu;
        alu_v = (a[15] != b[15]) && (res[15] != a[15]);
      end
      KIND_LOGIC: begin
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
      KIND_SHIFT: begin
        alu_c = c_alu;
        alu_v = 1'b0;
      end
      default: begin
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
    endcase
  end

  assign alu_flag = {alu_s, alu_z, alu_c, alu_v};

  assign stack_full  = (depth_q == 3'd4);
  assign stack_empty = (depth_q == 3'd0);

  assign conflict = push && pop;
  assign pop_ok   = pop && !push && !stack_empty;
  assign push_ok  = push && !pop && !stack_full;

  // Depth 4 wraps to index 0 in two bits, so subtracting one still lands on 3.
  assign top_idx = depth_q[1:0] - 2'd1;

  always_comb begin
    err_d = conflict || (push && stack_full) || (pop && stack_empty);

    flag_d = flag_q;
    if (pop_ok) begin
      flag_d = stack_mem[top_idx];
    end else if (wr_en) begin
      flag_d = wr_flag;
    end else if (op_valid) begin
      flag_d = alu_flag;
    end

    depth_d = depth_q;
    if (pop_ok) begin
      depth_d = depth_q - 3'd1;
    end else if (push_ok) begin
      depth_d = depth_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q  <= 4'b0000;
      depth_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Entries need no reset: they are only ever read below the depth pointer.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[depth_q[1:0]] <= flag_q;
    end
  end

  assign FLAG  = flag_q;
  assign depth = depth_q;
  assign err   = err_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Randomized + directed bench for flag_register_unit; a queue-based reference
// model predicts each cycle's outputs and a negedge monitor checks them.
module tb_flag_register_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_kind;
  logic [15:0] a, b, res;
  logic        c_alu;
  logic        wr_en;
  logic [3:0]  wr_flag;
  logic        push, pop;
  logic [3:0]  FLAG;
  logic [2:0]  depth;
  logic        stack_full, stack_empty, err;

  flag_register_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_kind(op_kind),
    .a(a), .b(b), .res(res), .c_alu(c_alu), .wr_en(wr_en), .wr_flag(wr_flag),
    .push(push), .pop(pop), .FLAG(FLAG), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flag;
    int         depth;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         passed = 0;
  int         txn = 0;

  logic [3:0] m_flag = 4'b0000;
  logic [3:0] m_stack[$];
  logic       m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic int to_signed(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic logic [3:0] ref_flags(input int kind, input logic [15:0] ta,
                                           input logic [15:0] tb, input logic [15:0] tr,
                                           input logic tc);
    int  sa, sb, sr;
    logic s, z, c, v;
    sa = to_signed(ta);
    sb = to_signed(tb);
    sr = to_signed(tr);
    s  = (sr < 0);
    z  = (tr == 0);
    c  = 1'b0;
    v  = 1'b0;
    if (kind == 0) begin
      c = tc;
      v = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
    end else if (kind == 1) begin
      c = tc;
      v = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
    end else if (kind == 3) begin
      c = tc;
    end
    return {s, z, c, v};
  endfunction

  task automatic step(input bit ov, input int kind, input logic [15:0] ta, input logic [15:0] tb,
                      input logic [15:0] tr, input bit tc, input bit twe, input logic [3:0] twf,
                      input bit tpu, input bit tpo);
    exp_t e;
    logic [3:0] next_flag;
    op_valid = ov; op_kind = kind[1:0]; a = ta; b = tb; res = tr; c_alu = tc;
    wr_en = twe; wr_flag = twf; push = tpu; pop = tpo;

    next_flag = m_flag;
    if (wr_en) next_flag = twf;
    else if (ov) next_flag = ref_flags(kind, ta, tb, tr, tc);
    m_err = 1'b0;
    if (tpu && tpo) begin
      m_err = 1'b1;
    end else if (tpo) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else next_flag = m_stack.pop_back();
    end else if (tpu) begin
      if (m_stack.size() == 4) m_err = 1'b1;
      else m_stack.push_back(m_flag);
    end
    m_flag = next_flag;

    @(posedge clk);
    e.flag = m_flag; e.depth = m_stack.size(); e.err = m_err;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle();       step(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0); endtask
  task automatic wr(input logic [3:0] f, input bit pu, input bit po);
    step(0, 0, 0, 0, 0, 0, 1, f, pu, po);
  endtask
  task automatic sp(input bit pu, input bit po); step(0, 0, 0, 0, 0, 0, 0, 4'h0, pu, po); endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d FLAG=%b depth=%0d full=%b empty=%b err=%b", txn, FLAG, depth,
                 stack_full, stack_empty, err);
        chk("flag", 32'(FLAG), 32'(e.flag));
        chk("depth", 32'(depth), 32'(e.depth));
        chk("err", 32'(err), 32'(e.err));
        chk("stack_full", 32'(stack_full), 32'(e.depth == 4));
        chk("stack_empty", 32'(stack_empty), 32'(e.depth == 0));
      end
    end
  end

  initial begin
    rst = 1'b1;
    op_valid = 0; op_kind = 0; a = 0; b = 0; res = 0; c_alu = 0;
    wr_en = 0; wr_flag = 0; push = 0; pop = 0;
    #1;
    chk("reset_flag", 32'(FLAG), 32'h0);
    chk("reset_depth", 32'(depth), 32'd0);
    chk("reset_empty", 32'(stack_empty), 32'd1);
    chk("reset_full", 32'(stack_full), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    idle();
    // Signed overflow on add, then zero result on sub, then logic clears C/V.
    step(1, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 4'h0, 0, 0);
    step(1, 1, 16'h0005, 16'h0005, 16'h0000, 0, 0, 4'h0, 0, 0);
    step(1, 2, 16'h1234, 16'h4321, 16'hFFFF, 1, 0, 4'h0, 0, 0);
    // Push saves the old flags while the same edge loads new ones.
    wr(4'b0100, 0, 0);
    step(1, 2, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 4'h0, 1, 0);
    sp(0, 1);
    // Overflow the stack, drain it, then underflow.
    for (int i = 0; i < 5; i++) wr(4'(i + 1), 1, 0);
    for (int i = 0; i < 4; i++) sp(0, 1);
    sp(0, 1);
    // Pop wins over wr_en and op_valid; push+pop together is rejected.
    wr(4'b0101, 0, 0);
    wr(4'b1010, 1, 0);
    sp(1, 0);
    step(1, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 4'b0011, 0, 1);
    step(1, 1, 16'h0001, 16'h0002, 16'hFFFF, 1, 0, 4'h0, 1, 1);
    // Build depth 3 with err high, then assert reset between edges.
    sp(1, 0);
    sp(1, 0);
    sp(1, 1);
    op_valid = 0; wr_en = 0; push = 0; pop = 0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_flag", 32'(FLAG), 32'h0);
    chk("async_depth", 32'(depth), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_empty", 32'(stack_empty), 32'd1);
    chk("async_full", 32'(stack_full), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_flag = 4'b0000; m_err = 1'b0; m_stack.delete();
    sp(0, 1);
    wr(4'b1111, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
           r, 1'($urandom), $urandom_range(0, 5) == 0, 4'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/flag_register_unit.md
FLAG_REGISTER_UNIT -- requirements
Module: flag_register_unit

Interface
REQ-001 SHALL provide port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL provide port op_valid, input, 1, ALU result present this cycle.
REQ-004 SHALL provide port op_kind, input, 2, 00 add / 01 sub / 10 logic / 11 shift.
REQ-005 SHALL provide ports a and b, input, 16 each, ALU operands.
REQ-006 SHALL provide port res, input, 16, ALU result.
REQ-007 SHALL provide port c_alu, input, 1, ALU carry-out (borrow for sub, shifted-out bit for shift).
REQ-008 SHALL provide ports wr_en, input, 1, and wr_flag, input, 4, for a direct flag load.
REQ-009 SHALL provide ports push and pop, input, 1 each, for flag save/restore.
REQ-010 SHALL provide port FLAG, output, 4, registered {S,Z,C,V} in the bit order the jump condition logic consumes.
REQ-011 SHALL provide ports depth (output, 3, stack occupancy 0..4), stack_full (output, 1), stack_empty (output, 1), err (output, 1, one-cycle pulse).

Function
REQ-012 SHALL compute S = res[15] and Z = (res == 0) for every op_kind.
REQ-013 SHALL compute, for add: C = c_alu, V = (a[15]==b[15]) && (res[15]!=a[15]).
REQ-014 SHALL compute, for sub: C = c_alu, V = (a[15]!=b[15]) && (res[15]!=a[15]).
REQ-015 SHALL compute, for logic: C = 0, V = 0; for shift: C = c_alu, V = 0.
REQ-016 SHALL update FLAG exactly one cycle after op_valid is sampled high; FLAG holds when no update source is active.
REQ-017 SHALL order FLAG update priority as pop (non-empty) > wr_en > op_valid; lower-priority sources in the same cycle are discarded.
REQ-018 SHALL implement a 4-entry LIFO; push stores the FLAG value present before the same edge's update, so push with op_valid saves the old flags while FLAG takes the new ones.
REQ-019 SHALL on pop with depth>0 load FLAG from the top entry and decrement depth.
REQ-020 SHALL on push with depth=4 ignore the push, leave stack and depth unchanged, and pulse err.
REQ-021 SHALL on pop with depth=0 ignore the pop, let wr_en/op_valid update FLAG normally, and pulse err.
REQ-022 SHALL treat push and pop in the same cycle as illegal: stack, depth and FLAG pop-path unchanged, wr_en/op_valid still honoured, err pulsed.
REQ-023 SHALL register err high for exactly the cycle after the offending edge; consecutive faults give consecutive pulses.
REQ-024 SHALL drive stack_full = (depth==4) and stack_empty = (depth==0) combinationally from the depth register.
REQ-025 SHALL ignore op_kind, a, b, res and c_alu when op_valid is low.

Reset
REQ-026 SHALL on rst asynchronously force FLAG=0000, depth=0, stack_empty=1, stack_full=0, err=0, regardless of clock.
REQ-027 SHALL, when rst asserts mid-operation, discard all stack contents and pending updates; first update occurs on the first rising edge with rst low.
REQ-028 SHALL leave stack entry storage contents unspecified after reset; they are unreadable because depth=0.

Verification
REQ-029 SHALL verify add a=7FFF, b=0001, res=8000, c_alu=0 -> next cycle FLAG=1001 (S=1,Z=0,C=0,V=1).
REQ-030 SHALL verify sub a=0005, b=0005, res=0000, c_alu=0 -> FLAG=0100; then logic res=FFFF with c_alu=1 -> FLAG=1000.
REQ-031 SHALL verify push with FLAG=0100 together with op_valid producing 1000 -> FLAG=1000, depth=1; then pop -> FLAG=0100, depth=0.
REQ-032 SHALL verify five pushes -> depth=4, stack_full=1, err pulses once on the fifth; pop on empty -> err pulse, depth stays 0.
REQ-033 SHALL verify same-cycle pop (depth=2), wr_en=0011 and op_valid -> FLAG=top entry, depth=1; push+pop together -> err pulse, depth unchanged.
REQ-034 SHALL verify rst asserted between clock edges with depth=3 -> FLAG=0000, depth=0, err=0 immediately, before the next edge.
